// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of the single CPU-side memory port
// among NUM_REQ requesters (0 = IM, 1 = DM, 2 = debug).
// Ports:
//   aclk, areset                    clock, async active-high reset
//   req_valid/write/addr/wdata/size per-requester command (packed, requester i in slice i)
//   req_done, req_err, rsp_rdata    one-hot completion/timeout pulse and read data to the winner
//   grant                           one-hot current owner
//   mem_read_request/write_request  one-cycle command pulses to the memory interface
//   mem_address/data_out/block_size latched command fields
//   mem_read_ready/write_finished   completion pulses, mem_data_in read data
//   timeout_sticky                  set on any timeout until reset
module mem_port_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*64-1:0]  req_addr,
    input  logic [NUM_REQ*64-1:0]  req_wdata,
    input  logic [NUM_REQ*2-1:0]   req_size,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_err,
    output logic [63:0]            rsp_rdata,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   mem_read_request,
    output logic                   mem_write_request,
    output logic [63:0]            mem_address,
    output logic [63:0]            mem_data_out,
    output logic [1:0]             mem_block_size,
    input  logic                   mem_read_ready,
    input  logic                   mem_write_finished,
    input  logic [63:0]            mem_data_in,
    output logic                   timeout_sticky
);

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;
    logic                 cmd_write, cmd_write_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;

    logic [NUM_REQ-1:0]   req_done_nxt, req_err_nxt, grant_nxt;
    logic [DATA_W-1:0]    rsp_rdata_nxt;
    logic                 mem_read_request_nxt, mem_write_request_nxt;
    logic [ADDR_W-1:0]    mem_address_nxt;
    logic [DATA_W-1:0]    mem_data_out_nxt;
    logic [SIZE_W-1:0]    mem_block_size_nxt;
    logic                 timeout_sticky_nxt;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx, cand;
    logic                 win_write;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;
    logic [SIZE_W-1:0]    win_size;
    logic [NUM_REQ-1:0]   owner_onehot;
    logic                 cpl_hit;

    // Round-robin scan starting just after the last winner, with wrap
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Select the winner's command fields
    always_comb begin
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        win_size  = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (IDX_W'(j) == win_idx) begin
                win_write = req_write[j];
                win_addr  = req_addr[j*ADDR_W +: ADDR_W];
                win_wdata = req_wdata[j*DATA_W +: DATA_W];
                win_size  = req_size[j*SIZE_W +: SIZE_W];
            end
        end
    end

    // rr_ptr doubles as the current owner index while a transaction is in flight
    assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << rr_ptr;
    assign cpl_hit      = cmd_write ? mem_write_finished : mem_read_ready;

    // Next-state and next-output logic
    always_comb begin
        state_nxt             = state;
        rr_ptr_nxt            = rr_ptr;
        cmd_write_nxt         = cmd_write;
        cnt_nxt               = cnt;
        grant_nxt             = grant;
        req_done_nxt          = '0;
        req_err_nxt           = '0;
        rsp_rdata_nxt         = rsp_rdata;
        mem_read_request_nxt  = 1'b0;
        mem_write_request_nxt = 1'b0;
        mem_address_nxt       = mem_address;
        mem_data_out_nxt      = mem_data_out;
        mem_block_size_nxt    = mem_block_size;
        timeout_sticky_nxt    = timeout_sticky;

        case (state)
            IDLE: begin
                grant_nxt = '0;
                if (win_found) begin
                    // Pulse is registered here so it is visible during ISSUE
                    rr_ptr_nxt            = win_idx;
                    cmd_write_nxt         = win_write;
                    grant_nxt             = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                    mem_address_nxt       = win_addr;
                    mem_data_out_nxt      = win_wdata;
                    mem_block_size_nxt    = win_size;
                    mem_read_request_nxt  = ~win_write;
                    mem_write_request_nxt = win_write;
                    state_nxt             = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt + CNT_W'(1);
                // Completion takes priority over a same-cycle timeout
                if (cpl_hit) begin
                    req_done_nxt = owner_onehot;
                    if (!cmd_write) begin
                        rsp_rdata_nxt = mem_data_in;
                    end
                    state_nxt = RESP;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    req_done_nxt       = owner_onehot;
                    req_err_nxt        = owner_onehot;
                    timeout_sticky_nxt = 1'b1;
                    state_nxt          = RESP;
                end
            end
            RESP: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state             <= IDLE;
            rr_ptr            <= IDX_W'(NUM_REQ - 1);
            cmd_write         <= 1'b0;
            cnt               <= '0;
            grant             <= '0;
            req_done          <= '0;
            req_err           <= '0;
            rsp_rdata         <= '0;
            mem_read_request  <= 1'b0;
            mem_write_request <= 1'b0;
            mem_address       <= '0;
            mem_data_out      <= '0;
            mem_block_size    <= '0;
            timeout_sticky    <= 1'b0;
        end else begin
            state             <= state_nxt;
            rr_ptr            <= rr_ptr_nxt;
            cmd_write         <= cmd_write_nxt;
            cnt               <= cnt_nxt;
            grant             <= grant_nxt;
            req_done          <= req_done_nxt;
            req_err           <= req_err_nxt;
            rsp_rdata         <= rsp_rdata_nxt;
            mem_read_request  <= mem_read_request_nxt;
            mem_write_request <= mem_write_request_nxt;
            mem_address       <= mem_address_nxt;
            mem_data_out      <= mem_data_out_nxt;
            mem_block_size    <= mem_block_size_nxt;
            timeout_sticky    <= timeout_sticky_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter (NUM_REQ=3, TIMEOUT_CYCLES=8).
module tb_mem_port_arbiter;

    localparam int unsigned NUM_REQ = 3;

    logic                  aclk;
    logic                  areset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*64-1:0] req_addr;
    logic [NUM_REQ*64-1:0] req_wdata;
    logic [NUM_REQ*2-1:0]  req_size;
    logic [NUM_REQ-1:0]    req_done;
    logic [NUM_REQ-1:0]    req_err;
    logic [63:0]           rsp_rdata;
    logic [NUM_REQ-1:0]    grant;
    logic                  mem_read_request;
    logic                  mem_write_request;
    logic [63:0]           mem_address;
    logic [63:0]           mem_data_out;
    logic [1:0]            mem_block_size;
    logic                  mem_read_ready;
    logic                  mem_write_finished;
    logic [63:0]           mem_data_in;
    logic                  timeout_sticky;

    int total;
    int bad;

    mem_port_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4)
    ) dut (
        .aclk               (aclk),
        .areset             (areset),
        .req_valid          (req_valid),
        .req_write          (req_write),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .req_size           (req_size),
        .req_done           (req_done),
        .req_err            (req_err),
        .rsp_rdata          (rsp_rdata),
        .grant              (grant),
        .mem_read_request   (mem_read_request),
        .mem_write_request  (mem_write_request),
        .mem_address        (mem_address),
        .mem_data_out       (mem_data_out),
        .mem_block_size     (mem_block_size),
        .mem_read_ready     (mem_read_ready),
        .mem_write_finished (mem_write_finished),
        .mem_data_in        (mem_data_in),
        .timeout_sticky     (timeout_sticky)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        logic [2:0]  exp_oh;
        logic [63:0] last_rdata;

        total = 0;
        bad   = 0;
        areset             = 1'b1;
        req_valid          = '0;
        req_write          = '0;
        req_addr           = '0;
        req_wdata          = '0;
        req_size           = '0;
        mem_read_ready     = 1'b0;
        mem_write_finished = 1'b0;
        mem_data_in        = '0;

        // Reset state
        #12;
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_done", 64'(req_done), 64'h0);
        check("rst_rdreq", 64'(mem_read_request), 64'h0);
        check("rst_addr", mem_address, 64'h0);
        check("rst_sticky", 64'(timeout_sticky), 64'h0);
        tick();
        areset = 1'b0;
        tick();

        // Single read by requester 1
        req_valid = 3'b010;
        req_addr[64 +: 64] = 64'h40;
        req_size[2 +: 2] = 2'b11;
        tick();  // ISSUE
        check("rd_grant", 64'(grant), 64'h2);
        check("rd_pulse", 64'(mem_read_request), 64'h1);
        check("rd_wrpulse", 64'(mem_write_request), 64'h0);
        check("rd_addr", mem_address, 64'h40);
        check("rd_size", 64'(mem_block_size), 64'h3);
        req_addr[64 +: 64] = 64'hFFFF;  // changes after latch must not matter
        tick();  // WAIT
        check("rd_pulse_end", 64'(mem_read_request), 64'h0);
        check("rd_addr_hold", mem_address, 64'h40);
        tick();  // WAIT, completion two cycles after pulse
        mem_read_ready = 1'b1;
        mem_data_in = 64'hDEADBEEF_01234567;
        tick();  // RESP
        check("rd_done", 64'(req_done), 64'h2);
        check("rd_err", 64'(req_err), 64'h0);
        check("rd_data", rsp_rdata, 64'hDEADBEEF_01234567);
        mem_read_ready = 1'b0;
        req_valid = '0;
        tick();  // IDLE
        check("rd_done_end", 64'(req_done), 64'h0);
        check("rd_grant_clr", 64'(grant), 64'h0);

        // Round-robin with all requesters held valid from reset
        areset = 1'b1;
        req_valid = 3'b111;
        req_write = 3'b000;
        tick();
        areset = 1'b0;
        for (int t = 0; t < 6; t++) begin
            exp_oh = 3'b001 << (t % 3);
            tick();  // ISSUE
            check("rr_grant", 64'(grant), 64'(exp_oh));
            tick();  // WAIT
            mem_read_ready = 1'b1;
            mem_data_in = 64'h1000 + 64'(t);
            tick();  // RESP
            check("rr_done", 64'(req_done), 64'(exp_oh));
            check("rr_data", rsp_rdata, 64'h1000 + 64'(t));
            mem_read_ready = 1'b0;
            if (t == 5) req_valid = '0;
            tick();  // IDLE
            check("rr_gap", 64'(grant), 64'h0);
        end
        last_rdata = 64'h1005;

        // Write by requester 2, stray read completion ignored
        req_valid = 3'b100;
        req_write = 3'b100;
        req_addr[128 +: 64] = 64'h1000;
        req_wdata[128 +: 64] = 64'h55;
        req_size[4 +: 2] = 2'b10;
        tick();  // ISSUE
        check("wr_grant", 64'(grant), 64'h4);
        check("wr_pulse", 64'(mem_write_request), 64'h1);
        check("wr_rdpulse", 64'(mem_read_request), 64'h0);
        check("wr_data", mem_data_out, 64'h55);
        check("wr_size", 64'(mem_block_size), 64'h2);
        check("wr_addr", mem_address, 64'h1000);
        tick();  // WAIT
        mem_read_ready = 1'b1;
        mem_data_in = 64'hBAD0_BAD0;
        tick();  // still WAIT
        check("wr_stray", 64'(req_done), 64'h0);
        mem_read_ready = 1'b0;
        mem_write_finished = 1'b1;
        tick();  // RESP
        check("wr_done", 64'(req_done), 64'h4);
        check("wr_rdata_keep", rsp_rdata, last_rdata);
        mem_write_finished = 1'b0;
        req_valid = '0;
        req_write = '0;
        tick();  // IDLE

        // Timeout on requester 0, no completion
        req_valid = 3'b001;
        tick();  // ISSUE
        check("to_grant", 64'(grant), 64'h1);
        for (int c = 0; c < 8; c++) tick();  // 8th WAIT cycle
        check("to_early", 64'(req_done), 64'h0);
        tick();  // RESP
        check("to_done", 64'(req_done), 64'h1);
        check("to_err", 64'(req_err), 64'h1);
        check("to_sticky", 64'(timeout_sticky), 64'h1);
        check("to_rdata", rsp_rdata, last_rdata);
        req_valid = '0;
        tick();  // IDLE
        mem_read_ready = 1'b1;
        mem_data_in = 64'h7777;
        tick();  // late completion in IDLE
        mem_read_ready = 1'b0;
        tick();
        check("to_late_done", 64'(req_done), 64'h0);
        check("to_late_data", rsp_rdata, last_rdata);
        check("to_sticky_hold", 64'(timeout_sticky), 64'h1);

        // Completion in the same cycle the counter reaches its limit
        req_valid = 3'b010;
        req_addr[64 +: 64] = 64'h80;
        tick();  // ISSUE
        check("tie_grant", 64'(grant), 64'h2);
        for (int c = 0; c < 7; c++) tick();  // 7th WAIT cycle
        tick();  // 8th WAIT cycle
        mem_read_ready = 1'b1;
        mem_data_in = 64'hCAFE_F00D;
        tick();  // RESP
        check("tie_done", 64'(req_done), 64'h2);
        check("tie_err", 64'(req_err), 64'h0);
        check("tie_data", rsp_rdata, 64'hCAFE_F00D);
        mem_read_ready = 1'b0;
        req_valid = '0;
        tick();  // IDLE

        // Async reset asserted between edges during WAIT
        req_valid = 3'b100;
        tick();  // ISSUE
        check("ar_grant", 64'(grant), 64'h4);
        tick();  // WAIT
        #2;
        areset = 1'b1;
        #1;
        check("ar_grant0", 64'(grant), 64'h0);
        check("ar_addr0", mem_address, 64'h0);
        check("ar_sticky0", 64'(timeout_sticky), 64'h0);
        check("ar_rdata0", rsp_rdata, 64'h0);
        req_valid = 3'b111;
        #3;
        areset = 1'b0;
        tick();  // ISSUE
        check("ar_first", 64'(grant), 64'h1);
        check("ar_done", 64'(req_done), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
